// File: rtl/scope_pkg.sv
// Shared scope definitions: SPI slave selects, ACK/NACK bytes and gain-DAC frame layout.
package scope_pkg;

  typedef enum logic [2:0] {
    SS_NONE    = 3'd0,
    SS_EEPROM  = 3'd1,
    SS_CH1     = 3'd2,
    SS_CH2     = 3'd3,
    SS_CH3     = 3'd4,
    SS_TRIGGER = 3'd5
  } slave_sel_t;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  // Gain DAC frame: {command nibble, register address, 8-bit gain code}.
  localparam logic [3:0] GAIN_DAC_WRITE = 4'h1;
  localparam logic [3:0] GAIN_DAC_CH1   = 4'h3;
  localparam logic [3:0] GAIN_DAC_CH2   = 4'h4;
  localparam logic [3:0] GAIN_DAC_CH3   = 4'h5;

  function automatic logic [15:0] gain_dac_frame(logic [3:0] addr, logic [7:0] code);
    return {GAIN_DAC_WRITE, addr, code};
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester and SPI-master signals of the shared SPI arbiter.
interface spi_arbiter_if #(parameter int NREQ = 3) ();
  import scope_pkg::*;

  // Handshake: req[i] is a level request held with a stable frame until done[i]
  // or err[i] pulses; gnt[i] stays high for the owned transaction. wrt_SPI is a
  // one-cycle launch and SPI_done a one-cycle completion with SPI_rd valid.
  logic [NREQ-1:0]    req;
  logic [3*NREQ-1:0]  req_ss;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [7:0]         rd_data;
  slave_sel_t         ss;
  logic               wrt_SPI;
  logic [15:0]        SPI_data;
  logic               SPI_done;
  logic [7:0]         SPI_rd;

  modport master (
    input  req, req_ss, req_data, SPI_done, SPI_rd,
    output gnt, done, err, rd_data, ss, wrt_SPI, SPI_data
  );

  modport slave (
    output req, req_ss, req_data, SPI_done, SPI_rd,
    input  gnt, done, err, rd_data, ss, wrt_SPI, SPI_data
  );
endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: nearest active request after ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] idx;

  // Scan farthest-first so the candidate closest to ptr+1 overwrites the rest.
  always_comb begin
    win     = '0;
    win_idx = '0;
    idx     = '0;
    any     = |req;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among frame requesters, with gap and hang timeout.
module spi_arbiter
  import scope_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_arbiter_if.master bus,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t          state;
  state_t          gap_next;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   tcnt;
  logic [3:0]      gcnt;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            any;
  slave_sel_t      sel_arr  [NREQ];
  logic [15:0]     data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign sel_arr[g]  = slave_sel_t'(bus.req_ss[3*g +: 3]);
    assign data_arr[g] = bus.req_data[16*g +: 16];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign gap_next  = (GAP_CYCLES == 0) ? IDLE : GAP;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // ptr doubles as the owner index for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= IW'(NREQ - 1);
      tcnt         <= '0;
      gcnt         <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.err      <= '0;
      bus.rd_data  <= '0;
      bus.ss       <= SS_NONE;
      bus.wrt_SPI  <= 1'b0;
      bus.SPI_data <= '0;
    end else begin
      bus.done    <= '0;
      bus.err     <= '0;
      bus.wrt_SPI <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            bus.gnt      <= win;
            bus.ss       <= sel_arr[win_idx];
            bus.SPI_data <= data_arr[win_idx];
            ptr          <= win_idx;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          tcnt <= '0;
          if (bus.ss == SS_NONE) begin
            bus.err[ptr] <= 1'b1;
            bus.gnt      <= '0;
            bus.SPI_data <= '0;
            gcnt         <= GAP_LOAD;
            state        <= gap_next;
          end else begin
            bus.wrt_SPI <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (bus.SPI_done) begin
            bus.rd_data   <= bus.SPI_rd;
            bus.done[ptr] <= 1'b1;
            bus.gnt       <= '0;
            bus.ss        <= SS_NONE;
            bus.SPI_data  <= '0;
            gcnt          <= GAP_LOAD;
            state         <= gap_next;
          end else if (tcnt == CW'(TIMEOUT)) begin
            bus.err[ptr] <= 1'b1;
            bus.gnt      <= '0;
            bus.ss       <= SS_NONE;
            bus.SPI_data <= '0;
            gcnt         <= GAP_LOAD;
            state        <= gap_next;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == 4'd0) state <= IDLE;
          else              gcnt  <= gcnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: main instance plus a short-timeout instance.
module tb_spi_arbiter;
  import scope_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;
  logic [1:0] st_a, st_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_arbiter_if #(.NREQ(3)) ifa ();
  spi_arbiter_if #(.NREQ(3)) ifb ();

  spi_arbiter #(.NREQ(3), .GAP_CYCLES(2), .TIMEOUT(4095)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a), .state_dbg(st_a)
  );

  spi_arbiter #(.NREQ(3), .GAP_CYCLES(2), .TIMEOUT(15)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .busy(busy_b), .state_dbg(st_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    ifa.req = '0; ifa.req_ss = '0; ifa.req_data = '0; ifa.SPI_done = 1'b0; ifa.SPI_rd = '0;
    ifb.req = '0; ifb.req_ss = '0; ifb.req_data = '0; ifb.SPI_done = 1'b0; ifb.SPI_rd = '0;
    do_reset;
    checks++; if (ifa.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", ifa.gnt); end
    checks++; if (ifa.done !== 3'b000 || ifa.err !== 3'b000) begin errors++; $display("FAIL reset_done_err: got %b/%b expected 000/000", ifa.done, ifa.err); end
    checks++; if (ifa.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", ifa.rd_data); end
    checks++; if (ifa.ss !== SS_NONE) begin errors++; $display("FAIL reset_ss: got %0d expected %0d", ifa.ss, SS_NONE); end
    checks++; if (ifa.wrt_SPI !== 1'b0 || ifa.SPI_data !== 16'h0000) begin errors++; $display("FAIL reset_spi: got %b/%h expected 0/0000", ifa.wrt_SPI, ifa.SPI_data); end
    checks++; if (busy_a !== 1'b0 || st_a !== 2'd0) begin errors++; $display("FAIL reset_busy: got %b/%0d expected 0/0", busy_a, st_a); end
  endtask

  task automatic test_single;
    int wrt_n;
    ifa.req_ss[2:0] = SS_CH1;
    ifa.req_data[15:0] = 16'h1328;
    ifa.req = 3'b001;
    tick;
    checks++; if (ifa.gnt !== 3'b001 || ifa.ss !== SS_CH1) begin errors++; $display("FAIL single_grant: got %b/%0d expected 001/%0d", ifa.gnt, ifa.ss, SS_CH1); end
    checks++; if (ifa.wrt_SPI !== 1'b0) begin errors++; $display("FAIL single_early_wrt: got %b expected 0", ifa.wrt_SPI); end
    tick;
    checks++; if (ifa.wrt_SPI !== 1'b1 || ifa.SPI_data !== 16'h1328) begin errors++; $display("FAIL single_launch: got %b/%h expected 1/1328", ifa.wrt_SPI, ifa.SPI_data); end
    wrt_n = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ifa.wrt_SPI === 1'b1) wrt_n++;
    end
    checks++; if (wrt_n !== 0) begin errors++; $display("FAIL single_wrt_once: got %0d extra pulses expected 0", wrt_n); end
    ifa.SPI_done = 1'b1; ifa.SPI_rd = 8'h3A;
    tick;
    ifa.SPI_done = 1'b0; ifa.req = 3'b000;
    checks++; if (ifa.done !== 3'b001) begin errors++; $display("FAIL single_done: got %b expected 001", ifa.done); end
    checks++; if (ifa.ss !== SS_NONE || ifa.gnt !== 3'b000) begin errors++; $display("FAIL single_release: got %0d/%b expected %0d/000", ifa.ss, ifa.gnt, SS_NONE); end
    checks++; if (ifa.rd_data !== 8'h3A) begin errors++; $display("FAIL single_rd: got %h expected 3a", ifa.rd_data); end
    tick;
    checks++; if (ifa.done !== 3'b000) begin errors++; $display("FAIL single_done_pulse: got %b expected 000", ifa.done); end
    tick;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy_a); end
  endtask

  task automatic test_eeprom_read;
    ifa.req_ss[5:3] = SS_EEPROM;
    ifa.req_data[31:16] = 16'h0A00;
    ifa.req = 3'b010;
    tick;
    checks++; if (ifa.gnt !== 3'b010 || ifa.ss !== SS_EEPROM) begin errors++; $display("FAIL eeprom_grant: got %b/%0d expected 010/%0d", ifa.gnt, ifa.ss, SS_EEPROM); end
    tick;
    checks++; if (ifa.wrt_SPI !== 1'b1 || ifa.SPI_data !== 16'h0A00) begin errors++; $display("FAIL eeprom_launch: got %b/%h expected 1/0a00", ifa.wrt_SPI, ifa.SPI_data); end
    repeat (3) tick;
    ifa.SPI_done = 1'b1; ifa.SPI_rd = 8'h5C;
    tick;
    ifa.SPI_done = 1'b0; ifa.SPI_rd = 8'hFF; ifa.req = 3'b000;
    checks++; if (ifa.done !== 3'b010) begin errors++; $display("FAIL eeprom_done: got %b expected 010", ifa.done); end
    checks++; if (ifa.rd_data !== 8'h5C) begin errors++; $display("FAIL eeprom_rd: got %h expected 5c", ifa.rd_data); end
    tick;
    checks++; if (ifa.rd_data !== 8'h5C) begin errors++; $display("FAIL eeprom_rd_hold: got %h expected 5c", ifa.rd_data); end
    repeat (2) tick;
  endtask

  task automatic test_contention;
    slave_sel_t  c_ss [3];
    logic [15:0] c_data [3];
    logic [2:0]  exp_g;
    int gap_n, zero_n, w;
    c_ss[0] = SS_CH1; c_ss[1] = SS_EEPROM; c_ss[2] = SS_CH2;
    c_data[0] = 16'h1111; c_data[1] = 16'h2222; c_data[2] = 16'h3333;
    do_reset;
    ifa.req_ss = {SS_CH2, SS_EEPROM, SS_CH1};
    ifa.req_data = {16'h3333, 16'h2222, 16'h1111};
    ifa.req = 3'b111;
    tick;
    for (int k = 0; k < 6; k++) begin
      w = k % 3;
      exp_g = 3'b001 << w;
      checks++; if (ifa.gnt !== exp_g || ifa.ss !== c_ss[w] || ifa.SPI_data !== c_data[w]) begin
        errors++; $display("FAIL contention_grant%0d: got %b/%0d/%h expected %b/%0d/%h", k, ifa.gnt, ifa.ss, ifa.SPI_data, exp_g, c_ss[w], c_data[w]);
      end
      tick;
      checks++; if (ifa.wrt_SPI !== 1'b1) begin errors++; $display("FAIL contention_wrt%0d: got %b expected 1", k, ifa.wrt_SPI); end
      tick;
      ifa.SPI_done = 1'b1; ifa.SPI_rd = 8'h40 + 8'(k);
      tick;
      ifa.SPI_done = 1'b0;
      if (k == 5) ifa.req = 3'b000;
      checks++; if (ifa.done !== exp_g || ifa.rd_data !== 8'h40 + 8'(k)) begin
        errors++; $display("FAIL contention_done%0d: got %b/%h expected %b/%h", k, ifa.done, ifa.rd_data, exp_g, 8'h40 + 8'(k));
      end
      if (k < 5) begin
        gap_n = 0; zero_n = 0;
        while (ifa.gnt === 3'b000 && zero_n < 20) begin
          if (st_a === 2'd3 && ifa.ss === SS_NONE) gap_n++;
          zero_n++;
          tick;
        end
        checks++; if (gap_n !== 2 || zero_n !== 3) begin
          errors++; $display("FAIL contention_gap%0d: got gap %0d idle-gnt %0d expected gap 2 idle-gnt 3", k, gap_n, zero_n);
        end
      end
    end
    repeat (3) tick;
  endtask

  task automatic test_illegal_select;
    int wrt_n;
    ifa.req_ss[2:0] = SS_NONE;
    ifa.req = 3'b001;
    tick;
    checks++; if (ifa.gnt !== 3'b001 || ifa.ss !== SS_NONE) begin errors++; $display("FAIL illegal_grant: got %b/%0d expected 001/%0d", ifa.gnt, ifa.ss, SS_NONE); end
    tick;
    ifa.req = 3'b000;
    checks++; if (ifa.err !== 3'b001 || ifa.wrt_SPI !== 1'b0) begin errors++; $display("FAIL illegal_err: got %b/%b expected 001/0", ifa.err, ifa.wrt_SPI); end
    wrt_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (ifa.wrt_SPI === 1'b1 || ifa.done !== 3'b000) wrt_n++;
    end
    checks++; if (wrt_n !== 0) begin errors++; $display("FAIL illegal_no_launch: got %0d bad cycles expected 0", wrt_n); end
  endtask

  task automatic test_timeout;
    int bad_n;
    ifb.req_ss[2:0] = SS_CH2;  ifb.req_data[15:0]  = 16'h1455;
    ifb.req_ss[5:3] = SS_CH3;  ifb.req_data[31:16] = 16'h1566;
    ifb.req = 3'b011;
    tick;
    checks++; if (ifb.gnt !== 3'b001) begin errors++; $display("FAIL timeout_grant: got %b expected 001", ifb.gnt); end
    tick;
    checks++; if (ifb.wrt_SPI !== 1'b1) begin errors++; $display("FAIL timeout_launch: got %b expected 1", ifb.wrt_SPI); end
    bad_n = 0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      if (ifb.err !== 3'b000 || ifb.done !== 3'b000) bad_n++;
    end
    checks++; if (bad_n !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles expected 0", bad_n); end
    tick;
    ifb.req = 3'b010;
    checks++; if (ifb.err !== 3'b001 || ifb.done !== 3'b000) begin errors++; $display("FAIL timeout_err: got %b/%b expected 001/000", ifb.err, ifb.done); end
    checks++; if (ifb.gnt !== 3'b000 || ifb.ss !== SS_NONE) begin errors++; $display("FAIL timeout_release: got %b/%0d expected 000/%0d", ifb.gnt, ifb.ss, SS_NONE); end
    repeat (3) tick;
    checks++; if (ifb.gnt !== 3'b010 || ifb.ss !== SS_CH3) begin errors++; $display("FAIL timeout_next: got %b/%0d expected 010/%0d", ifb.gnt, ifb.ss, SS_CH3); end
  endtask

  task automatic test_done_on_timeout;
    tick;
    checks++; if (ifb.wrt_SPI !== 1'b1) begin errors++; $display("FAIL tie_launch: got %b expected 1", ifb.wrt_SPI); end
    repeat (15) tick;
    ifb.SPI_done = 1'b1; ifb.SPI_rd = 8'hC3;
    tick;
    ifb.SPI_done = 1'b0; ifb.req = 3'b000;
    checks++; if (ifb.done !== 3'b010 || ifb.err !== 3'b000) begin errors++; $display("FAIL tie_done: got %b/%b expected 010/000", ifb.done, ifb.err); end
    checks++; if (ifb.rd_data !== 8'hC3) begin errors++; $display("FAIL tie_rd: got %h expected c3", ifb.rd_data); end
    tick;
    checks++; if (ifb.err !== 3'b000) begin errors++; $display("FAIL tie_late_err: got %b expected 000", ifb.err); end
    repeat (3) tick;
  endtask

  task automatic test_reset_mid_wait;
    ifa.req_ss[8:6] = SS_TRIGGER;
    ifa.req_data[47:32] = 16'hBEEF;
    ifa.req = 3'b100;
    tick;
    checks++; if (ifa.gnt !== 3'b100) begin errors++; $display("FAIL rstwait_grant: got %b expected 100", ifa.gnt); end
    repeat (3) tick;
    checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL rstwait_in_wait: got %0d expected 2", st_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.ss !== SS_NONE || ifa.gnt !== 3'b000 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rstwait_async: got %0d/%b/%b expected %0d/000/0", ifa.ss, ifa.gnt, busy_a, SS_NONE);
    end
    ifa.req_ss = {SS_TRIGGER, SS_EEPROM, SS_CH1};
    ifa.req = 3'b111;
    tick;
    rst_n = 1'b1;
    tick;
    checks++; if (ifa.gnt !== 3'b001) begin errors++; $display("FAIL rstwait_first_grant: got %b expected 001", ifa.gnt); end
    ifa.req = 3'b000;
    do_reset;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_eeprom_read;
    test_contention;
    test_illegal_select;
    test_timeout;
    test_done_on_timeout;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the scope's single SPI master among several command sources: the UART command dispatcher, the power-up calibration loader that restores channel gains and trigger level from EEPROM, and the auto-range block. Each requester presents a complete 16-bit SPI frame plus a slave select. The arbiter grants one requester at a time in round-robin order, launches the frame, routes completion or read-back data to the winner, and enforces an inter-frame gap and a hang timeout.

## Interface
Parameters:
- NREQ, 3: number of requesters; index 0 is the command dispatcher.
- GAP_CYCLES, 2: idle cycles between frames, range 0..15.
- TIMEOUT, 4095: cycles allowed from launch to SPI_done; counter width is $clog2(TIMEOUT+1).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, NREQ: per-requester level request; held until the requester sees done or err.
- req_ss, input, NREQ×3: packed SlaveSelect per requester; requester i uses bits [3i+2:3i].
- req_data, input, NREQ×16: packed SPI frame per requester.
- gnt, output, NREQ: one-hot grant, high for the whole owned transaction.
- done, output, NREQ: one-cycle completion pulse to the owner.
- err, output, NREQ: one-cycle pulse on timeout or illegal select.
- rd_data, output, 8: SPI read-back byte, valid with done and held until the next done.
- ss, output, 3 (SlaveSelect): select to the SPI master; SS_NONE when idle.
- wrt_SPI, output, 1: one-cycle launch pulse to the SPI master.
- SPI_data, output, 16: frame to the SPI master, held while ss is not SS_NONE.
- SPI_done, input, 1: transfer complete from the SPI master.
- SPI_rd, input, 8: byte returned by the SPI master, valid when SPI_done is high.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any req is set, choose winner w by round-robin, searching from ptr+1 upward with wrap.
  - Register gnt[w], ss=req_ss[w] and SPI_data=req_data[w]; set ptr=w; go to LAUNCH.
- LAUNCH:
  - wrt_SPI=1 for exactly this cycle; clear the timeout counter.
  - If the latched ss is SS_NONE: do not assert wrt_SPI, pulse err[w], go to GAP.
  - Otherwise go to WAIT.
- WAIT: the counter increments each cycle.
  - SPI_done=1: capture SPI_rd into rd_data, pulse done[w], go to GAP.
  - Counter reaches TIMEOUT: pulse err[w], go to GAP.
  - SPI_done and timeout in the same cycle: done wins and err is not pulsed.
- GAP:
  - On entry, gnt=0, ss=SS_NONE and SPI_data=0.
  - Remain for GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Frames are latched at grant, so requester changes to req_ss or req_data after grant have no effect.
- A req deasserted after grant does not abort the transaction; done or err is still pulsed.
- A req deasserted before grant is never serviced.
- SPI_done outside WAIT is ignored.
- ptr reset value is NREQ-1, so requester 0 wins first after reset.

## Timing
- Reset values: state=IDLE, gnt=0, done=0, err=0, rd_data=0, ss=SS_NONE, wrt_SPI=0, SPI_data=0, busy=0, ptr=NREQ-1, counter=0.
- All outputs are registered.
- req sampled in cycle t: gnt and ss are valid at t+1 and wrt_SPI is high at t+2.
- SPI_done high in cycle u: done and rd_data are valid at u+1, and gnt drops at u+1.
- Next possible grant: u+2+GAP_CYCLES.
- Timeout: err is pulsed TIMEOUT+1 cycles after wrt_SPI if SPI_done never arrives.
- Minimum requester duty: a requester that reasserts req the cycle after done competes in the next IDLE. Round-robin guarantees every active requester is served within NREQ transactions.

## Structure
- The shared package scope_pkg holds:
  - the SlaveSelect enum (SS_NONE, SS_EEPROM, SS_CH1, SS_CH2, SS_CH3, SS_TRIGGER);
  - the ACK/NACK constants;
  - the gain-DAC frame constants.
- FSM state enum is local to the module.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: one-hot win, win index, any.
- Timeout counter and gap counter are inline.

## Test plan
- Single request: req[0]=1, req_ss[0]=SS_CH1, req_data[0]=16'h1328; SPI_done 20 cycles after wrt_SPI.
  - Expect one wrt_SPI with SPI_data=16'h1328 and ss=SS_CH1.
  - Expect done[0] one cycle after SPI_done, then ss=SS_NONE.
- EEPROM read: req[1], frame 16'h0A00, SPI_rd=8'h5C with SPI_done.
  - Expect rd_data=8'h5C with done[1]=1, and done[0]=0 and done[2]=0.
- Contention: all three req held continuously for 6 transactions.
  - Expect grant order 0,1,2,0,1,2.
  - Expect a gap of exactly GAP_CYCLES=2 cycles with ss=SS_NONE between frames.
- Timeout: TIMEOUT=15, SPI_done never asserted.
  - Expect err[w] 16 cycles after wrt_SPI, no done pulse, then the arbiter services the next request.
- Illegal select and simultaneous events:
  - req_ss=SS_NONE: expect err pulsed, wrt_SPI never asserted.
  - SPI_done on the timeout cycle: expect done pulsed, err not pulsed.
- Reset mid-WAIT: assert rst_n=0.
  - Expect immediate ss=SS_NONE, gnt=0, busy=0.
  - After release, the next grant goes to requester 0.
